imm_gen_stage: RTL and testbench

Registered, parametrised immediate generator for the RISC-V core decode path. It accepts one 32-bit instruction and its PC per cycle over a valid/ready handshake. It classifies the instruction format, produces the sign- or zero-extended immediate at XLEN width, and computes the PC-relative sum. Results leave through a 2-entry skid buffer so the decode stage can stall without creating a combinational ready path.

---
 rtl/imm_gen_stage.sv | 182 ++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator: classifies the instruction format, builds the
// XLEN-wide immediate and pc+imm target, and hands results out through a 2-entry skid buffer.
module imm_gen_stage #(
   parameter int XLEN     = 32,
   parameter int RV64_OPS = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   localparam bit RV64_EN = (XLEN == 64) && (RV64_OPS != 0);

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_AMO       = 7'b0101111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_Z     = 3'd6;
   localparam logic [2:0] FMT_SHAMT = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_shift;
   logic [2:0]      dec_fmt;
   logic            dec_illegal;
   logic            shamt_wide;
   logic [XLEN-1:0] dec_imm;
   entry_t          dec_entry;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   always_comb begin
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      shamt_wide  = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_MISC_MEM, OPC_JALR: dec_fmt = FMT_I;
         OPC_OP_IMM: begin
            dec_fmt    = is_shift ? FMT_SHAMT : FMT_I;
            shamt_wide = (XLEN == 64);
         end
         OPC_STORE:            dec_fmt = FMT_S;
         OPC_BRANCH:           dec_fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:   dec_fmt = FMT_U;
         OPC_JAL:              dec_fmt = FMT_J;
         OPC_SYSTEM:           dec_fmt = funct3[2] ? FMT_Z : FMT_NONE;
         OPC_OP, OPC_AMO:      dec_fmt = FMT_NONE;
         OPC_OP_IMM_32: begin
            // word shifts keep a 5-bit shamt even on RV64
            if (RV64_EN) dec_fmt = is_shift ? FMT_SHAMT : FMT_I;
            else         dec_illegal = 1'b1;
         end
         OPC_OP_32: begin
            if (!RV64_EN) dec_illegal = 1'b1;
         end
         default:              dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec_imm = '0;
      case (dec_fmt)
         FMT_I: dec_imm = XLEN'($signed(in_instr[31:20]));
         FMT_S: dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         FMT_B: dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
         FMT_U: dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         FMT_J: dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
         FMT_Z: dec_imm = XLEN'(in_instr[19:15]);
         FMT_SHAMT: begin
            if (shamt_wide) dec_imm = XLEN'(in_instr[25:20]);
            else            dec_imm = XLEN'(in_instr[24:20]);
         end
         default: dec_imm = '0;
      endcase
   end

   assign dec_entry.imm     = dec_imm;
   assign dec_entry.target  = in_pc + dec_imm;
   assign dec_entry.fmt     = dec_fmt;
   assign dec_entry.illegal = dec_illegal;

   entry_t e0, e1;
   logic   e0_valid, e1_valid;
   logic   e0_valid_nxt, e1_valid_nxt;
   logic   e0_load_new, e0_load_e1, e1_load;
   logic   accept, consume;

   assign accept  = in_valid & in_ready;
   assign consume = e0_valid & out_ready;

   // e1 is only ever occupied while e0 is; in_ready mirrors !e1 so accept implies e1 free
   always_comb begin
      e0_valid_nxt = e0_valid;
      e1_valid_nxt = e1_valid;
      e0_load_new  = 1'b0;
      e0_load_e1   = 1'b0;
      e1_load      = 1'b0;
      if (flush) begin
         e0_valid_nxt = 1'b0;
         e1_valid_nxt = 1'b0;
      end else if (!e0_valid) begin
         if (accept) begin
            e0_load_new  = 1'b1;
            e0_valid_nxt = 1'b1;
         end
      end else if (consume) begin
         if (e1_valid) begin
            e0_load_e1   = 1'b1;
            e1_valid_nxt = 1'b0;
         end else if (accept) begin
            e0_load_new  = 1'b1;
         end else begin
            e0_valid_nxt = 1'b0;
         end
      end else if (accept) begin
         e1_load      = 1'b1;
         e1_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e0_valid <= 1'b0;
         e1_valid <= 1'b0;
         e0       <= '0;
         e1       <= '0;
         in_ready <= 1'b0;
      end else begin
         e0_valid <= e0_valid_nxt;
         e1_valid <= e1_valid_nxt;
         in_ready <= !e1_valid_nxt;
         if (e0_load_new)     e0 <= dec_entry;
         else if (e0_load_e1) e0 <= e1;
         if (e1_load)         e1 <= dec_entry;
      end
   end

   assign out_valid   = e0_valid;
   assign out_imm     = e0.imm;
   assign out_fmt     = e0.fmt;
   assign out_target  = e0.target;
   assign out_illegal = e0.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 instance and one XLEN=64/RV64_OPS=1 instance.
module tb_imm_gen_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_illegal;
   logic [31:0] a_in_instr = 0, a_in_pc = 0, a_out_imm, a_out_target;
   logic [2:0]  a_out_fmt;

   logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_illegal;
   logic [31:0] b_in_instr = 0;
   logic [63:0] b_in_pc = 0, b_out_imm, b_out_target;
   logic [2:0]  b_out_fmt;

   imm_gen_stage #(.XLEN(32), .RV64_OPS(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
      .out_fmt(a_out_fmt), .out_target(a_out_target), .out_illegal(a_out_illegal));

   imm_gen_stage #(.XLEN(64), .RV64_OPS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
      .out_fmt(b_out_fmt), .out_target(b_out_target), .out_illegal(b_out_illegal));

   // hand-decoded vectors, XLEN=32
   logic [31:0] t32_instr [12] = '{32'hAAAAA993, 32'hFFFFFFEF, 32'hFFFFFFB3, 32'hFE112E23,
                                   32'h12345037, 32'h0000007F, 32'hFE000EE3, 32'h340FD073,
                                   32'h03F09093, 32'h00001097, 32'h00000073, 32'h0000009B};
   logic [31:0] t32_imm   [12] = '{32'hFFFFFAAA, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFC,
                                   32'h12345000, 32'h0, 32'hFFFFFFFC, 32'h1F,
                                   32'h1F, 32'h1000, 32'h0, 32'h0};
   logic [2:0]  t32_fmt   [12] = '{3'd1, 3'd5, 3'd0, 3'd2, 3'd4, 3'd0, 3'd3, 3'd6,
                                   3'd7, 3'd4, 3'd0, 3'd0};
   logic        t32_ill   [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

   // hand-decoded vectors, XLEN=64 with RV64 word ops
   logic [31:0] t64_instr [7] = '{32'h800000B7, 32'h03F09093, 32'h0000009B, 32'h03F0909B,
                                  32'h000000BB, 32'hFFFFFFEF, 32'hAAAAA993};
   logic [63:0] t64_imm   [7] = '{64'hFFFFFFFF80000000, 64'd63, 64'd0, 64'd31,
                                  64'd0, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFAAA};
   logic [2:0]  t64_fmt   [7] = '{3'd4, 3'd7, 3'd1, 3'd7, 3'd0, 3'd5, 3'd1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 1'b1; a_in_instr = 32'h00100093; a_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_instr = 32'h00100093; b_out_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_imm !== 32'h0 ||
          a_out_target !== 32'h0 || a_out_fmt !== 3'd0 || a_out_illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset32 got v=%b r=%b imm=%h tgt=%h fmt=%0d ill=%b exp all zero",
                  a_out_valid, a_in_ready, a_out_imm, a_out_target, a_out_fmt, a_out_illegal);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 || b_out_imm !== 64'h0 ||
          b_out_target !== 64'h0 || b_out_fmt !== 3'd0 || b_out_illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset64 got v=%b r=%b imm=%h tgt=%h fmt=%0d ill=%b exp all zero",
                  b_out_valid, b_in_ready, b_out_imm, b_out_target, b_out_fmt, b_out_illegal);
      end
      rst_n = 1'b1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      tick();
      checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got ready32=%b ready64=%b v32=%b exp 1 1 0",
                  a_in_ready, b_in_ready, a_out_valid);
      end
   endtask

   task automatic test_formats32();
      a_out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a_in_valid = 1'b1; a_in_instr = t32_instr[i]; a_in_pc = 32'h100;
         tick();
         a_in_valid = 1'b0;
         checks++;
         if (a_out_valid !== 1'b1 || a_out_imm !== t32_imm[i] || a_out_fmt !== t32_fmt[i] ||
             a_out_illegal !== t32_ill[i] || a_out_target !== 32'h100 + t32_imm[i]) begin
            failures++;
            $display("FAIL fmt32[%0d] got v=%b imm=%h fmt=%0d ill=%b tgt=%h exp v=1 imm=%h fmt=%0d ill=%b tgt=%h",
                     i, a_out_valid, a_out_imm, a_out_fmt, a_out_illegal, a_out_target,
                     t32_imm[i], t32_fmt[i], t32_ill[i], 32'h100 + t32_imm[i]);
         end
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL fmt32_drain got out_valid=%b exp 0", a_out_valid);
      end
   endtask

   task automatic test_rv64();
      b_out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         b_in_valid = 1'b1; b_in_instr = t64_instr[i]; b_in_pc = 64'h100;
         tick();
         b_in_valid = 1'b0;
         checks++;
         if (b_out_valid !== 1'b1 || b_out_imm !== t64_imm[i] || b_out_fmt !== t64_fmt[i] ||
             b_out_illegal !== 1'b0 || b_out_target !== 64'h100 + t64_imm[i]) begin
            failures++;
            $display("FAIL fmt64[%0d] got v=%b imm=%h fmt=%0d ill=%b tgt=%h exp v=1 imm=%h fmt=%0d ill=0 tgt=%h",
                     i, b_out_valid, b_out_imm, b_out_fmt, b_out_illegal, b_out_target,
                     t64_imm[i], t64_fmt[i], 64'h100 + t64_imm[i]);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      a_out_ready = 1'b0;
      a_in_pc = 32'h200;
      a_in_valid = 1'b1; a_in_instr = 32'h00100093;
      tick();
      a_in_instr = 32'h00200093;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'd1 || a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first got v=%b imm=%h ready=%b exp 1 1 1", a_out_valid, a_out_imm, a_in_ready);
      end
      tick();
      a_in_instr = 32'h00300093;
      checks++;
      if (a_out_imm !== 32'd1 || a_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_full got imm=%h ready=%b exp imm=1 ready=0", a_out_imm, a_in_ready);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'd1 || a_out_target !== 32'h201 || a_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_hold got v=%b imm=%h tgt=%h ready=%b exp 1 1 201 0",
                  a_out_valid, a_out_imm, a_out_target, a_in_ready);
      end
      a_out_ready = 1'b1;
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'd2 || a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_b got v=%b imm=%h ready=%b exp 1 2 1", a_out_valid, a_out_imm, a_in_ready);
      end
      tick();
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'd3 || a_out_target !== 32'h203) begin
         failures++;
         $display("FAIL bp_c got v=%b imm=%h tgt=%h exp 1 3 203", a_out_valid, a_out_imm, a_out_target);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_empty got out_valid=%b exp 0", a_out_valid);
      end
   endtask

   task automatic test_flush();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_instr = 32'h00500093;
      tick();
      a_in_instr = 32'h00600093;
      tick();
      a_in_instr = 32'h00700093; a_flush = 1'b1;
      tick();
      a_flush = 1'b0; a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_full got v=%b ready=%b exp 0 1", a_out_valid, a_in_ready);
      end
      a_out_ready = 1'b1;
      repeat (2) tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_leak got out_valid=%b imm=%h exp 0", a_out_valid, a_out_imm);
      end
      // one entry held and in_ready high: the offered input must still be dropped
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_instr = 32'h00500093;
      tick();
      a_in_instr = 32'h00800093; a_flush = 1'b1;
      tick();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_one got v=%b imm=%h ready=%b exp 0 1", a_out_valid, a_out_imm, a_in_ready);
      end
      tick();
      a_in_valid = 1'b1; a_in_instr = 32'h00900093;
      tick();
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== 32'd9) begin
         failures++;
         $display("FAIL flush_resume got v=%b imm=%h exp 1 9", a_out_valid, a_out_imm);
      end
      tick();
   endtask

   task automatic test_reset_midstream();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_instr = 32'h00400093;
      tick();
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_imm !== 32'h0 || a_out_target !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid got v=%b ready=%b imm=%h tgt=%h exp 0 0 0 0",
                  a_out_valid, a_in_ready, a_out_imm, a_out_target);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_release got ready=%b v=%b exp 1 0", a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_random();
      int          q_idx[$];
      logic [31:0] q_pc[$];
      int          hi;
      logic [31:0] hp;
      int          sel;
      for (int cyc = 0; cyc < 420; cyc++) begin
         if (cyc < 400) begin
            sel = $urandom_range(0, 11);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_in_instr  = t32_instr[sel];
            a_in_pc     = $urandom;
         end else begin
            a_in_valid  = 1'b0;
            a_out_ready = 1'b1;
         end
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (q_idx.size() == 0) begin
               failures++;
               $display("FAIL random_extra got unexpected imm=%h exp no output", a_out_imm);
            end else begin
               hi = q_idx.pop_front();
               hp = q_pc.pop_front();
               if (a_out_imm !== t32_imm[hi] || a_out_fmt !== t32_fmt[hi] ||
                   a_out_illegal !== t32_ill[hi] || a_out_target !== hp + t32_imm[hi]) begin
                  failures++;
                  $display("FAIL random_item got imm=%h fmt=%0d ill=%b tgt=%h exp imm=%h fmt=%0d ill=%b tgt=%h",
                           a_out_imm, a_out_fmt, a_out_illegal, a_out_target,
                           t32_imm[hi], t32_fmt[hi], t32_ill[hi], hp + t32_imm[hi]);
               end
            end
         end
         if (a_in_valid && a_in_ready) begin
            q_idx.push_back(sel);
            q_pc.push_back(a_in_pc);
         end
         tick();
      end
      checks++;
      if (q_idx.size() != 0 || a_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL random_drain got pending=%0d out_valid=%b exp 0 0", q_idx.size(), a_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_formats32();
      test_rv64();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
